// File: rtl/fb_scanout_reader.sv
// Frame-buffer scanout reader: prefetches pixels in raster order through a
// grant-based read port into a small in-order FIFO and emits one colour per pixel strobe.
module fb_scanout_reader #(
    parameter int                 H_ACTIVE        = 640,
    parameter int                 V_ACTIVE        = 480,
    parameter int                 FIFO_DEPTH      = 8,
    parameter int                 COLOR_W         = 24,
    parameter logic [COLOR_W-1:0] UNDERFLOW_COLOR = 24'hFF00FF
) (
    input  logic               Clk,
    input  logic               Reset_n,
    input  logic               VS,
    input  logic               Pix_En,
    input  logic               Blank_n,
    output logic               Rd_Req,
    output logic [9:0]         Rd_X,
    output logic [9:0]         Rd_Y,
    input  logic               Rd_Gnt,
    input  logic               Rd_Valid,
    input  logic [COLOR_W-1:0] Rd_Data,
    output logic [COLOR_W-1:0] Pix_Color,
    output logic               Underflow,
    output logic [3:0]         Fifo_Level
);

    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = $clog2(FIFO_DEPTH + 1);
    localparam int DISC_W = CNT_W + 4;

    typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;

    state_t              state_q, state_d;
    logic                vs_meta, vs_sync, vs_prev;
    logic                fs;
    logic [CNT_W-1:0]    level_q, outstanding_q;
    logic [DISC_W-1:0]   discard_q, discard_d;
    logic [PTR_W-1:0]    wr_ptr_q, rd_ptr_q;
    logic [COLOR_W-1:0]  mem [FIFO_DEPTH];
    logic [CNT_W:0]      credit_used;
    logic                accept, last_pixel, pop, pop_hit, push;
    logic                ret_discard, ret_live;

    // Sync flops come out of reset high so a VS already high is not mistaken for a frame start.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            vs_meta <= 1'b1;
            vs_sync <= 1'b1;
            vs_prev <= 1'b1;
        end else begin
            vs_meta <= VS;
            vs_sync <= vs_meta;
            vs_prev <= vs_sync;
        end
    end

    assign fs          = vs_sync & ~vs_prev;
    assign credit_used = {1'b0, level_q} + {1'b0, outstanding_q};
    assign Rd_Req      = (state_q == FETCH) && (credit_used < (CNT_W+1)'(FIFO_DEPTH));
    assign accept      = Rd_Req & Rd_Gnt;
    assign last_pixel  = (Rd_X == 10'(H_ACTIVE - 1)) && (Rd_Y == 10'(V_ACTIVE - 1));
    assign ret_discard = Rd_Valid && (discard_q != '0);
    assign ret_live    = Rd_Valid && (discard_q == '0) && (outstanding_q != '0);
    assign push        = ret_live && !fs;
    assign pop         = Pix_En & Blank_n;
    assign pop_hit     = pop && (level_q != '0) && !fs;
    assign Fifo_Level  = 4'(level_q);

    always_comb begin
        state_d = state_q;
        if (fs)
            state_d = FETCH;
        else if (state_q == FETCH && accept && last_pixel)
            state_d = DRAIN;
        else if (state_q == DRAIN && outstanding_q == '0 && level_q == '0)
            state_d = IDLE;
    end

    // Every read still in flight at frame start, including one granted in that very cycle,
    // must be dropped on return; a return in the same cycle retires one of them.
    always_comb begin
        discard_d = discard_q;
        if (fs)
            discard_d = discard_q + DISC_W'(outstanding_q) + DISC_W'(accept)
                      - DISC_W'(ret_discard | ret_live);
        else if (ret_discard)
            discard_d = discard_q - DISC_W'(1);
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q       <= IDLE;
            level_q       <= '0;
            outstanding_q <= '0;
            discard_q     <= '0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            Rd_X          <= '0;
            Rd_Y          <= '0;
        end else begin
            state_q   <= state_d;
            discard_q <= discard_d;
            if (fs) begin
                level_q       <= '0;
                outstanding_q <= '0;
                wr_ptr_q      <= '0;
                rd_ptr_q      <= '0;
                Rd_X          <= '0;
                Rd_Y          <= '0;
            end else begin
                level_q       <= level_q + CNT_W'(push) - CNT_W'(pop_hit);
                outstanding_q <= outstanding_q + CNT_W'(accept) - CNT_W'(ret_live);
                wr_ptr_q      <= wr_ptr_q + PTR_W'(push);
                rd_ptr_q      <= rd_ptr_q + PTR_W'(pop_hit);
                if (accept) begin
                    if (Rd_X == 10'(H_ACTIVE - 1)) begin
                        Rd_X <= '0;
                        Rd_Y <= Rd_Y + 10'd1;
                    end else begin
                        Rd_X <= Rd_X + 10'd1;
                    end
                end
            end
        end
    end

    // NOTE: the FIFO storage has no reset; level and pointers alone define what is valid.
    always_ff @(posedge Clk) begin
        if (push)
            mem[wr_ptr_q] <= Rd_Data;
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            Pix_Color <= '0;
            Underflow <= 1'b0;
        end else if (pop) begin
            if (pop_hit) begin
                Pix_Color <= mem[rd_ptr_q];
            end else begin
                Pix_Color <= UNDERFLOW_COLOR;
                Underflow <= 1'b1;
            end
        end else if (Pix_En) begin
            Pix_Color <= '0;
        end
    end

endmodule

// File: tb/tb_fb_scanout_reader.sv
// Randomised bench for fb_scanout_reader: a queue-based model of the frame reader
// predicts every output each cycle while a bench-side arbiter/memory answers reads.
module tb_fb_scanout_reader;

    localparam int          H     = 640;
    localparam int          V     = 4;
    localparam int          DEPTH = 8;
    localparam logic [23:0] UF    = 24'hFF00FF;

    logic        Clk = 1'b0;
    logic        Reset_n, VS, Pix_En, Blank_n, Rd_Gnt, Rd_Valid;
    logic [23:0] Rd_Data;
    logic        Rd_Req, Underflow;
    logic [9:0]  Rd_X, Rd_Y;
    logic [23:0] Pix_Color;
    logic [3:0]  Fifo_Level;

    fb_scanout_reader #(.H_ACTIVE(H), .V_ACTIVE(V), .FIFO_DEPTH(DEPTH)) dut (
        .Clk(Clk), .Reset_n(Reset_n), .VS(VS), .Pix_En(Pix_En), .Blank_n(Blank_n),
        .Rd_Req(Rd_Req), .Rd_X(Rd_X), .Rd_Y(Rd_Y), .Rd_Gnt(Rd_Gnt),
        .Rd_Valid(Rd_Valid), .Rd_Data(Rd_Data), .Pix_Color(Pix_Color),
        .Underflow(Underflow), .Fifo_Level(Fifo_Level)
    );

    always #10 Clk = ~Clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Bench-side arbiter/memory: answers each granted read in order after a latency.
    typedef struct { int due; logic [23:0] data; } resp_t;
    resp_t resp_q[$];
    int    last_due = 0;
    int    lat      = 2;
    bit    pause    = 0;

    // Reference model: frame position, in-flight reads (marked stale by a frame start), FIFO.
    typedef enum {M_IDLE, M_FETCH, M_DRAIN} mphase_t;
    typedef struct { bit stale; logic [23:0] data; } req_t;
    req_t        m_inq[$];
    logic [23:0] m_fifo[$];
    mphase_t     m_phase;
    int          m_x, m_y, m_acc;
    logic [23:0] m_pix;
    bit          m_uf, m_s0, m_s1, m_s2;

    int cyc     = 0;
    int dut_acc = 0;
    int log_x[8] = '{default: -1};
    int log_y[8] = '{default: -1};
    int log_n   = 0;
    bit wrap_done = 0;

    function automatic int m_live();
        int n = 0;
        foreach (m_inq[i]) if (!m_inq[i].stale) n++;
        return n;
    endfunction

    function automatic bit m_req();
        return (m_phase == M_FETCH) && (m_fifo.size() + m_live() < DEPTH);
    endfunction

    task automatic model_reset();
        m_inq.delete();
        m_fifo.delete();
        m_phase = M_IDLE;
        m_x = 0; m_y = 0; m_acc = 0;
        m_pix = '0; m_uf = 0;
        m_s0 = 1; m_s1 = 1; m_s2 = 1;
        resp_q.delete();
        last_due = 0;
    endtask

    task automatic model_edge();
        bit   fs, req, acc, pop, drain_done;
        req_t e;
        fs  = m_s1 && !m_s2;
        m_s2 = m_s1; m_s1 = m_s0; m_s0 = VS;
        req = m_req();
        acc = req && Rd_Gnt;
        pop = Pix_En && Blank_n;
        drain_done = (m_phase == M_DRAIN) && (m_live() == 0) && (m_fifo.size() == 0);
        if (pop) begin
            if (!fs && m_fifo.size() > 0) m_pix = m_fifo.pop_front();
            else begin m_pix = UF; m_uf = 1; end
        end else if (Pix_En) begin
            m_pix = '0;
        end
        if (Rd_Valid && m_inq.size() > 0) begin
            e = m_inq.pop_front();
            if (!e.stale && !fs) m_fifo.push_back(e.data);
        end
        if (acc) begin
            e.stale = fs;
            e.data  = {m_y[7:0], m_x[7:0], 8'hA5};
            m_inq.push_back(e);
        end
        if (fs) begin
            m_fifo.delete();
            foreach (m_inq[i]) m_inq[i].stale = 1;
            m_x = 0; m_y = 0; m_acc = 0;
            m_phase = M_FETCH;
        end else if (acc) begin
            m_acc++;
            if (m_x == H - 1 && m_y == V - 1) m_phase = M_DRAIN;
            if (m_x == H - 1) begin m_x = 0; m_y++; end
            else m_x++;
        end else if (drain_done) begin
            m_phase = M_IDLE;
        end
    endtask

    task automatic compare_outputs();
        check("rd_req", Rd_Req, m_req());
        check("rd_x", Rd_X, m_x);
        check("rd_y", Rd_Y, m_y);
        check("level", Fifo_Level, m_fifo.size());
        check("pix", Pix_Color, m_pix);
        check("uf", Underflow, m_uf);
    endtask

    // One clock: drive the return bus, log a grant, advance model, then compare after the edge.
    task automatic step();
        resp_t r;
        if (!pause && resp_q.size() > 0 && resp_q[0].due <= cyc) begin
            Rd_Valid = 1'b1;
            Rd_Data  = resp_q[0].data;
            void'(resp_q.pop_front());
        end else begin
            Rd_Valid = 1'b0;
            Rd_Data  = 24'($urandom);
        end
        if (Rd_Req && Rd_Gnt) begin
            r.due  = (cyc + lat > last_due) ? cyc + lat : last_due + 1;
            r.data = {Rd_Y[7:0], Rd_X[7:0], 8'hA5};
            resp_q.push_back(r);
            last_due = r.due;
            if (log_n < 8) begin log_x[log_n] = Rd_X; log_y[log_n] = Rd_Y; log_n++; end
            dut_acc++;
        end
        model_edge();
        @(posedge Clk);
        #1;
        cyc++;
        compare_outputs();
    endtask

    task automatic frame_start();
        VS = 1'b0;
        repeat (3) step();
        VS = 1'b1;
        repeat (4) step();
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_req"}, Rd_Req, 0);
        check({tag, "_x"}, Rd_X, 0);
        check({tag, "_y"}, Rd_Y, 0);
        check({tag, "_level"}, Fifo_Level, 0);
        check({tag, "_pix"}, Pix_Color, 0);
        check({tag, "_uf"}, Underflow, 0);
    endtask

    initial begin
        Reset_n = 1'b0; VS = 1'b1; Pix_En = 1'b0; Blank_n = 1'b0;
        Rd_Gnt = 1'b0; Rd_Valid = 1'b0; Rd_Data = '0;
        model_reset();
        #3;
        check_zero("init");
        repeat (2) @(posedge Clk);
        #1;
        Reset_n = 1'b1;

        // Fill from frame start with no pops: exactly one FIFO's worth of requests.
        repeat (5) step();
        Rd_Gnt = 1'b1; lat = 2; dut_acc = 0;
        frame_start();
        repeat (25) step();
        check("req_before_pop", dut_acc, 8);
        check("level_full", Fifo_Level, 8);
        for (int i = 0; i < 8; i++) begin
            check("seq_x", log_x[i], i);
            check("seq_y", log_y[i], 0);
        end
        check("uf_clear", Underflow, 0);

        // Grant starvation while popping: address holds, then the FIFO runs dry.
        Rd_Gnt = 1'b0; Pix_En = 1'b1; Blank_n = 1'b1;
        repeat (20) begin
            step();
            check("starve_x", Rd_X, 8);
            check("starve_y", Rd_Y, 0);
            check("starve_req", Rd_Req, 1);
        end
        check("uf_color", Pix_Color, UF);
        check("uf_flag", Underflow, 1);

        // Random grants, latencies, strobes and blanking; ordering checked every cycle.
        repeat (300) begin
            Rd_Gnt  = ($urandom_range(0, 3) != 0);
            lat     = $urandom_range(1, 4);
            Pix_En  = 1'($urandom_range(0, 1));
            Blank_n = ($urandom_range(0, 3) != 0);
            step();
        end
        check("uf_sticky", Underflow, 1);

        // Mid-frame restart with 5 in the FIFO and 3 reads outstanding.
        Pix_En = 1'b0; Blank_n = 1'b1; Rd_Gnt = 1'b1; lat = 2;
        repeat (20) step();
        check("d_full", Fifo_Level, 8);
        pause = 1;
        Pix_En = 1'b1;
        repeat (3) step();
        Pix_En = 1'b0;
        repeat (4) step();
        check("d_level5", Fifo_Level, 5);
        Rd_Gnt = 1'b0;
        frame_start();
        check("fs_flush", Fifo_Level, 0);
        check("fs_x", Rd_X, 0);
        pause = 0;
        repeat (5) step();
        check("stale_drop", Fifo_Level, 0);
        Rd_Gnt = 1'b1;
        repeat (8) step();
        Rd_Gnt = 1'b0;
        Pix_En = 1'b1;
        step();
        check("first_after_fs", Pix_Color, 24'h0000A5);
        step();
        check("second_after_fs", Pix_Color, 24'h0001A5);
        Pix_En = 1'b0;

        // Whole frame: line wrap at H, DRAIN after the last pixel, back to idle.
        frame_start();
        dut_acc = 0;
        for (int n = 0; n < 20000 && dut_acc < H * V; n++) begin
            Rd_Gnt  = ($urandom_range(0, 3) != 0);
            lat     = $urandom_range(1, 3);
            Pix_En  = ($urandom_range(0, 3) != 0);
            Blank_n = 1'b1;
            step();
            if (!wrap_done && m_acc == H) begin
                wrap_done = 1;
                check("wrap_x", Rd_X, 0);
                check("wrap_y", Rd_Y, 1);
            end
        end
        check("frame_acc", dut_acc, H * V);
        check("drain_req", Rd_Req, 0);
        Pix_En = 1'b1; Rd_Gnt = 1'b1;
        repeat (30) step();
        check("drain_level", Fifo_Level, 0);
        check("idle_req", Rd_Req, 0);

        // Asynchronous reset between edges in the middle of fetching.
        Pix_En = 1'b0;
        frame_start();
        repeat (6) step();
        #5;
        Reset_n = 1'b0;
        #1;
        check_zero("async_rst");
        model_reset();
        Rd_Valid = 1'b0;
        repeat (2) @(posedge Clk);
        #3;
        Reset_n = 1'b1;
        Rd_Gnt = 1'b1;
        repeat (20) begin
            step();
            check("rst_no_req", Rd_Req, 0);
        end
        frame_start();
        step();
        check("req_after_fs", Rd_Req, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fb_scanout_reader.md
Name: fb_scanout_reader

Overview:
Read-side engine of the frame buffer. The ray-tracing FSM writes pixels via WritePixel/WriteX/WriteY; this block reads them back in raster order for VGA display. It prefetches pixels into a small in-order FIFO through a grant-based read port, since the writer has priority at the arbiter. It then delivers one colour per displayed pixel strobe. Single clock domain (CLOCK_50); the pixel rate is expressed as an enable strobe.

Parameters:
H_ACTIVE, 640, visible pixels per line
V_ACTIVE, 480, visible lines per frame
FIFO_DEPTH, 8, prefetch entries (power of 2, >=4)
COLOR_W, 24, colour width ({B,G,R} 8 bits each)
UNDERFLOW_COLOR, 24'hFF00FF, colour emitted when the FIFO is empty on a pop

Ports:
Clk  in  1  system clock (CLOCK_50)
Reset_n  in  1  asynchronous, active-low reset
VS  in  1  VGA vertical sync (active low); the rising edge starts a new frame
Pix_En  in  1  one-cycle strobe per pixel slot from the VGA timing
Blank_n  in  1  high during the active display region, qualifies Pix_En
Rd_Req  out  1  read request to the frame buffer arbiter
Rd_X  out  10  pixel column of the request
Rd_Y  out  10  pixel row of the request
Rd_Gnt  in  1  arbiter accepts the request this cycle
Rd_Valid  in  1  read data returning, in request order
Rd_Data  in  COLOR_W  returned colour
Pix_Color  out  COLOR_W  registered colour to the DAC
Underflow  out  1  sticky: a pop occurred with the FIFO empty
Fifo_Level  out  4  current FIFO occupancy

Behaviour:
- Reset (asynchronous, Reset_n=0): all outputs are 0.
  - State=IDLE, Rd_X=Rd_Y=0, FIFO empty, outstanding=0, discard=0, Underflow=0, Pix_Color=0.
- VS is synchronised through 2 flops; frame start is a synchronised 0->1 edge, giving 1-cycle pulse FS.
- States:
  - IDLE: Rd_Req=0. On FS go to FETCH.
  - FETCH: issue requests.
  - DRAIN: all H_ACTIVE*V_ACTIVE requests have been accepted; wait for outstanding=0 and FIFO empty, then go to IDLE.
- FS in any state (including mid-FETCH/DRAIN):
  - flush the FIFO (level=0);
  - Rd_X=Rd_Y=0;
  - discard += outstanding, outstanding=0;
  - next state FETCH.
  - FS takes priority over every same-cycle event except Reset_n.
- Request rule in FETCH: Rd_Req=1 when level+outstanding < FIFO_DEPTH.
  - Rd_X/Rd_Y hold stable while Rd_Req=1 and Rd_Gnt=0.
  - Acceptance = Rd_Req & Rd_Gnt. On acceptance, outstanding+1.
  - Rd_X+1; at Rd_X=H_ACTIVE-1, Rd_X wraps to 0 and Rd_Y+1.
  - Acceptance at (H_ACTIVE-1, V_ACTIVE-1) sends the FSM to DRAIN; Rd_Req=0 the following cycle.
  - Rd_Gnt while Rd_Req=0 is ignored.
- Return rule, on Rd_Valid:
  - if discard>0: drop the data, discard-1;
  - else: push Rd_Data into the FIFO, outstanding-1.
  - Rd_Valid with outstanding=0 and discard=0 is a protocol error; the data is dropped.
- Overflow cannot occur by construction (the credit rule). A simultaneous push and pop leaves the level unchanged.
- Pop = Pix_En & Blank_n.
  - On pop with level>0: Pix_Color <= FIFO head on the next clock (1-cycle latency).
  - On pop with level=0: Pix_Color <= UNDERFLOW_COLOR, Underflow <= 1; Rd_X/Rd_Y are not advanced, so the image shifts rather than stalling.
  - Pix_En & ~Blank_n: Pix_Color <= 0.
  - No Pix_En: Pix_Color holds.
- Underflow clears only on reset.
- Fifo_Level reflects the registered occupancy.
- Pointers are log2(FIFO_DEPTH) bits and wrap naturally; level is a separate counter 0..FIFO_DEPTH.

Test Plan:
- Reset then FS, Rd_Gnt=1 always, Rd_Valid 2 cycles after each grant:
  - exactly 8 requests issue before the first pop;
  - Rd_X sequence 0..7, Rd_Y=0;
  - Fifo_Level reaches 8.
- Line wrap: after 640 acceptances, the next request is Rd_X=0, Rd_Y=1. After 307200 acceptances, the state is DRAIN and Rd_Req=0.
- Grant starvation: hold Rd_Gnt=0 for 20 cycles with Rd_Req=1.
  - Rd_X/Rd_Y stay constant.
  - Popping with Pix_En & Blank_n after the FIFO empties gives Pix_Color=24'hFF00FF and Underflow=1, sticky.
- Data ordering: return Rd_Data = {Rd_Y[7:0], Rd_X[7:0], 8'hA5} per request; Pix_Color on successive pops matches the request order exactly.
- Mid-frame FS with 3 outstanding and 5 in the FIFO:
  - the level drops to 0;
  - the next 3 Rd_Valid are dropped;
  - the 4th Rd_Valid carries pixel (0,0) into the FIFO.
- Asynchronous Reset_n pulse mid-FETCH between clock edges: outputs are 0 immediately; no Rd_Req until the next FS.
